pacman_move_ctrl: RTL

Pac-Man position/direction controller that sits directly downstream of the 4-bit legal-move lookup. It consumes leg_l/leg_r/leg_u/leg_d for the current cell and drives the pixel position (xpos/ypos) back into that lookup and to the sprite renderer. It buffers joystick requests, allows turns only at cell-aligned positions, and steps the sprite once per frame tick.

---
 rtl/pacman_pkg.sv | 39 +++
 rtl/pacman_axis_stepper.sv | 88 ++++++++
 rtl/pacman_move_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared encodings and grid geometry for the Pac-Man movement path
// (legal-move lookup, movement controller, sprite renderer).
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_L = 2'b00,
        DIR_R = 2'b01,
        DIR_U = 2'b10,
        DIR_D = 2'b11
    } dir_t;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_MOVE = 1'b1
    } mv_state_t;

    localparam int PM_CELL      = 60;
    localparam int PM_STEP      = 2;
    localparam int PM_ORIGIN_X  = 150;
    localparam int PM_ORIGIN_Y  = 34;
    localparam int PM_GRID      = 8;
    localparam int PM_START_COL = 0;
    localparam int PM_START_ROW = 0;
    localparam int POS_W        = 10;
    localparam int IDX_W        = 3;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        case (d)
            DIR_L:   r = DIR_R;
            DIR_R:   r = DIR_L;
            DIR_U:   r = DIR_D;
            DIR_D:   r = DIR_U;
            default: r = DIR_R;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pacman_axis_stepper.sv
// One axis of sprite motion: pixel position, sub-cell offset and cell index,
// advanced by STEP pixels whenever step_en_i is high.
module pacman_axis_stepper
    import pacman_pkg::*;
#(
    parameter int CELL_P   = PM_CELL,
    parameter int STEP_P   = PM_STEP,
    parameter int ORIGIN_P = 0,
    parameter int GRID_P   = PM_GRID,
    parameter int START_P  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en_i,
    input  logic             step_neg_i,
    output logic [POS_W-1:0] pos_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             aligned_o,
    output logic             aligned_next_o,
    output logic             at_lo_o,
    output logic             at_hi_o
);

    localparam int OFF_W = $clog2(CELL_P);
    localparam logic [POS_W-1:0] POS_RST  = POS_W'(ORIGIN_P + CELL_P * START_P);
    localparam logic [POS_W-1:0] POS_STEP = POS_W'(STEP_P);
    localparam logic [OFF_W-1:0] OFF_STEP = OFF_W'(STEP_P);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(CELL_P - STEP_P);
    localparam logic [OFF_W-1:0] OFF_ZERO = OFF_W'(0);
    localparam logic [IDX_W-1:0] IDX_RST  = IDX_W'(START_P);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(GRID_P - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Next position/offset/index; a leftward step from an aligned spot
    // lands in the previous cell, index saturates at the grid edges.
    always_comb begin
        pos_d = pos_q;
        off_d = off_q;
        idx_d = idx_q;
        if (step_en_i) begin
            if (step_neg_i) begin
                pos_d = pos_q - POS_STEP;
                if (off_q == OFF_ZERO) begin
                    off_d = OFF_LAST;
                    idx_d = (idx_q != IDX_ZERO) ? (idx_q - IDX_ONE) : idx_q;
                end else begin
                    off_d = off_q - OFF_STEP;
                end
            end else begin
                pos_d = pos_q + POS_STEP;
                if (off_q == OFF_LAST) begin
                    off_d = OFF_ZERO;
                    idx_d = (idx_q != IDX_MAX) ? (idx_q + IDX_ONE) : idx_q;
                end else begin
                    off_d = off_q + OFF_STEP;
                end
            end
        end else begin
            pos_d = pos_q;
        end
    end

    // Axis state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= POS_RST;
            off_q <= OFF_ZERO;
            idx_q <= IDX_RST;
        end else begin
            pos_q <= pos_d;
            off_q <= off_d;
            idx_q <= idx_d;
        end
    end

    assign pos_o          = pos_q;
    assign idx_o          = idx_q;
    assign aligned_o      = (off_q == OFF_ZERO);
    assign aligned_next_o = (off_d == OFF_ZERO);
    assign at_lo_o        = (idx_q == IDX_ZERO);
    assign at_hi_o        = (idx_q == IDX_MAX);

endmodule

// File: rtl/pacman_move_ctrl.sv
// Pac-Man position/direction controller: buffers joystick requests, turns only
// at cell-aligned positions, reverses anywhere, and steps once per move_tick.
module pacman_move_ctrl
    import pacman_pkg::*;
#(
    parameter int CELL      = PM_CELL,
    parameter int STEP      = PM_STEP,
    parameter int ORIGIN_X  = PM_ORIGIN_X,
    parameter int ORIGIN_Y  = PM_ORIGIN_Y,
    parameter int GRID      = PM_GRID,
    parameter int START_COL = PM_START_COL,
    parameter int START_ROW = PM_START_ROW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             move_tick,
    input  logic             btn_l,
    input  logic             btn_r,
    input  logic             btn_u,
    input  logic             btn_d,
    input  logic             leg_l,
    input  logic             leg_r,
    input  logic             leg_u,
    input  logic             leg_d,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic [IDX_W-1:0] cell_x,
    output logic [IDX_W-1:0] cell_y,
    output logic [1:0]       dir,
    output logic             moving,
    output logic             cell_entered
);

    mv_state_t state_q, state_d;
    dir_t      dir_q, dir_d;
    dir_t      req_q, req_d;
    logic      req_valid_q, req_valid_d;
    logic      moving_q;
    logic      cell_entered_q;

    dir_t       btn_dir_s, eff_req_s;
    logic       btn_any_s, eff_valid_s;
    logic       step_s, take_req_s;
    logic [3:0] legal_s;
    logic       x_aligned_s, y_aligned_s, x_next_al_s, y_next_al_s;
    logic       x_lo_s, x_hi_s, y_lo_s, y_hi_s;

    assign btn_any_s   = btn_l | btn_r | btn_u | btn_d;
    assign eff_valid_s = btn_any_s | req_valid_q;
    assign eff_req_s   = btn_any_s ? btn_dir_s : req_q;

    // Highest-priority pressed button (L > R > U > D).
    always_comb begin
        if (btn_l) begin
            btn_dir_s = DIR_L;
        end else if (btn_r) begin
            btn_dir_s = DIR_R;
        end else if (btn_u) begin
            btn_dir_s = DIR_U;
        end else begin
            btn_dir_s = DIR_D;
        end
    end

    // Legality per direction, with the grid edge overriding the lookup.
    always_comb begin
        legal_s = 4'b0000;
        legal_s[DIR_L] = leg_l & ~x_lo_s;
        legal_s[DIR_R] = leg_r & ~x_hi_s;
        legal_s[DIR_U] = leg_u & ~y_lo_s;
        legal_s[DIR_D] = leg_d & ~y_hi_s;
    end

    // Tick decision: start, turn, continue, reverse or stop.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        step_s     = 1'b0;
        take_req_s = 1'b0;
        if (move_tick) begin
            case (state_q)
                ST_STOP: begin
                    if (eff_valid_s && legal_s[eff_req_s]) begin
                        dir_d      = eff_req_s;
                        state_d    = ST_MOVE;
                        step_s     = 1'b1;
                        take_req_s = 1'b1;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_MOVE: begin
                    if (x_aligned_s && y_aligned_s) begin
                        if (eff_valid_s && legal_s[eff_req_s]) begin
                            dir_d      = eff_req_s;
                            step_s     = 1'b1;
                            take_req_s = 1'b1;
                        end else if (legal_s[dir_q]) begin
                            step_s = 1'b1;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        // Mid-cell: only a reversal is honoured; perpendicular
                        // requests wait in the buffer for the next alignment.
                        if (eff_valid_s && (eff_req_s == opposite(dir_q))) begin
                            dir_d      = eff_req_s;
                            take_req_s = 1'b1;
                        end else begin
                            dir_d = dir_q;
                        end
                        step_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_STOP;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Request buffer next state.
    always_comb begin
        req_d       = req_q;
        req_valid_d = req_valid_q;
        if (take_req_s) begin
            req_valid_d = 1'b0;
        end else if (btn_any_s) begin
            req_valid_d = 1'b1;
        end else begin
            req_valid_d = req_valid_q;
        end
        if (btn_any_s) begin
            req_d = btn_dir_s;
        end else begin
            req_d = req_q;
        end
    end

    // Movement FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_STOP;
            dir_q          <= DIR_R;
            req_q          <= DIR_R;
            req_valid_q    <= 1'b0;
            moving_q       <= 1'b0;
            cell_entered_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            req_q          <= req_d;
            req_valid_q    <= req_valid_d;
            moving_q       <= (state_d == ST_MOVE);
            cell_entered_q <= step_s & x_next_al_s & y_next_al_s;
        end
    end

    pacman_axis_stepper #(
        .CELL_P   (CELL),
        .STEP_P   (STEP),
        .ORIGIN_P (ORIGIN_X),
        .GRID_P   (GRID),
        .START_P  (START_COL)
    ) u_x (
        .clk            (clk),
        .rst            (rst),
        .step_en_i      (step_s & ~dir_d[1]),
        .step_neg_i     (~dir_d[0]),
        .pos_o          (xpos),
        .idx_o          (cell_x),
        .aligned_o      (x_aligned_s),
        .aligned_next_o (x_next_al_s),
        .at_lo_o        (x_lo_s),
        .at_hi_o        (x_hi_s)
    );

    pacman_axis_stepper #(
        .CELL_P   (CELL),
        .STEP_P   (STEP),
        .ORIGIN_P (ORIGIN_Y),
        .GRID_P   (GRID),
        .START_P  (START_ROW)
    ) u_y (
        .clk            (clk),
        .rst            (rst),
        .step_en_i      (step_s & dir_d[1]),
        .step_neg_i     (~dir_d[0]),
        .pos_o          (ypos),
        .idx_o          (cell_y),
        .aligned_o      (y_aligned_s),
        .aligned_next_o (y_next_al_s),
        .at_lo_o        (y_lo_s),
        .at_hi_o        (y_hi_s)
    );

    assign dir          = dir_q;
    assign moving       = moving_q;
    assign cell_entered = cell_entered_q;

endmodule
